// File: rtl/gpo_pulse_bank.sv
// Dual-port register-mapped bank of GPO channels. A data write drives DIN for LEN
// cycles and then returns to GPO_DFT; LEN = 0 latches the written value instead.
module gpo_pulse_ch #(
  parameter int               DW      = 8,
  parameter int               CNT_W   = 8,
  parameter logic [DW-1:0]    GPO_DFT = '0,
  parameter logic [CNT_W-1:0] LEN_DFT = CNT_W'(1)
) (
  input  logic             SYSCLK,
  input  logic             RESET_N,
  input  logic             i_wr1_dat,
  input  logic             i_wr2_dat,
  input  logic             i_wr1_len,
  input  logic             i_wr2_len,
  input  logic [DW-1:0]    i_din1,
  input  logic [DW-1:0]    i_din2,
  input  logic [CNT_W-1:0] i_len1,
  input  logic [CNT_W-1:0] i_len2,
  output logic [DW-1:0]    o_do,
  output logic [CNT_W-1:0] o_len,
  output logic             o_active
);
  logic [DW-1:0]    r_do;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_cnt;

  // A trigger always reloads from the pre-edge length, so a length write in the
  // same cycle only affects the following trigger.
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_do  <= GPO_DFT;
      r_cnt <= '0;
    end else if (i_wr1_dat) begin
      r_do  <= i_din1;
      r_cnt <= r_len;
    end else if (i_wr2_dat) begin
      r_do  <= i_din2;
      r_cnt <= r_len;
    end else if (r_cnt > CNT_W'(1)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end else if (r_cnt == CNT_W'(1)) begin
      r_cnt <= '0;
      r_do  <= GPO_DFT;
    end
  end

  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N)       r_len <= LEN_DFT;
    else if (i_wr1_len) r_len <= i_len1;
    else if (i_wr2_len) r_len <= i_len2;
  end

  assign o_do     = r_do;
  assign o_len    = r_len;
  assign o_active = (r_cnt != '0);
endmodule

module gpo_pulse_bank #(
  parameter int               NUM_CH  = 16,
  parameter int               DW      = 8,
  parameter int               CNT_W   = 8,
  parameter logic [DW-1:0]    GPO_DFT = '0,
  parameter logic [CNT_W-1:0] LEN_DFT = CNT_W'(1)
) (
  input  logic                   SYSCLK,
  input  logic                   RESET_N,
  input  logic                   PORT_CS1,
  input  logic                   PORT_CS2,
  input  logic [2*NUM_CH-1:0]    OFFSET_SEL1,
  input  logic [2*NUM_CH-1:0]    OFFSET_SEL2,
  input  logic                   RD_WR1,
  input  logic                   RD_WR2,
  input  logic [DW-1:0]          DIN1,
  input  logic [DW-1:0]          DIN2,
  output logic [DW-1:0]          DOUT1,
  output logic [DW-1:0]          DOUT2,
  output logic [NUM_CH*DW-1:0]   DO,
  output logic [NUM_CH-1:0]      ACTIVE
);
  localparam int MIN_W = (CNT_W < DW) ? CNT_W : DW;

  logic [2*NUM_CH-1:0]            w_wr1, w_wr2;
  logic                           w_rd1, w_rd2;
  logic [CNT_W-1:0]               w_din_len1, w_din_len2;
  logic [NUM_CH-1:0][DW-1:0]      w_do;
  logic [NUM_CH-1:0][CNT_W-1:0]   w_len;
  logic [DW-1:0]                  w_rdata1, w_rdata2;
  logic [DW-1:0]                  r_dout1, r_dout2;

  // Truncate or zero-extend between the data bus and length register widths.
  function automatic logic [CNT_W-1:0] f_to_len(input logic [DW-1:0] d);
    f_to_len = '0;
    for (int b = 0; b < MIN_W; b++) f_to_len[b] = d[b];
  endfunction

  function automatic logic [DW-1:0] f_to_dat(input logic [CNT_W-1:0] l);
    f_to_dat = '0;
    for (int b = 0; b < MIN_W; b++) f_to_dat[b] = l[b];
  endfunction

  assign w_wr1      = {(2*NUM_CH){PORT_CS1 & ~RD_WR1}} & OFFSET_SEL1;
  assign w_wr2      = {(2*NUM_CH){PORT_CS2 & ~RD_WR2}} & OFFSET_SEL2;
  assign w_rd1      = PORT_CS1 & RD_WR1;
  assign w_rd2      = PORT_CS2 & RD_WR2;
  assign w_din_len1 = f_to_len(DIN1);
  assign w_din_len2 = f_to_len(DIN2);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    gpo_pulse_ch #(
      .DW(DW), .CNT_W(CNT_W), .GPO_DFT(GPO_DFT), .LEN_DFT(LEN_DFT)
    ) u_ch (
      .SYSCLK    (SYSCLK),
      .RESET_N   (RESET_N),
      .i_wr1_dat (w_wr1[i]),
      .i_wr2_dat (w_wr2[i]),
      .i_wr1_len (w_wr1[NUM_CH+i]),
      .i_wr2_len (w_wr2[NUM_CH+i]),
      .i_din1    (DIN1),
      .i_din2    (DIN2),
      .i_len1    (w_din_len1),
      .i_len2    (w_din_len2),
      .o_do      (w_do[i]),
      .o_len     (w_len[i]),
      .o_active  (ACTIVE[i])
    );
  end

  // Multiple select bits OR the selected registers together.
  always_comb begin
    w_rdata1 = '0;
    w_rdata2 = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (OFFSET_SEL1[i])        w_rdata1 = w_rdata1 | w_do[i];
      if (OFFSET_SEL1[NUM_CH+i]) w_rdata1 = w_rdata1 | f_to_dat(w_len[i]);
      if (OFFSET_SEL2[i])        w_rdata2 = w_rdata2 | w_do[i];
      if (OFFSET_SEL2[NUM_CH+i]) w_rdata2 = w_rdata2 | f_to_dat(w_len[i]);
    end
  end

  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_dout1 <= '0;
      r_dout2 <= '0;
    end else begin
      if (w_rd1) r_dout1 <= w_rdata1;
      if (w_rd2) r_dout2 <= w_rdata2;
    end
  end

  assign DOUT1 = r_dout1;
  assign DOUT2 = r_dout2;
  assign DO    = w_do;
endmodule

// File: tb/tb_gpo_pulse_bank.sv
// Bench for gpo_pulse_bank: directed scenarios plus randomized traffic against a
// trigger-time/length reference model; a second instance covers wide, FFFF-idle parameters.
module tb_gpo_pulse_bank;
  localparam int NC = 16, DW = 8, CW = 8;
  localparam logic [DW-1:0] DFT = 8'h00;
  localparam int NC2 = 4, DW2 = 16;

  logic SYSCLK = 1'b0;
  logic RESET_N;
  logic cs1, cs2, rw1, rw2;
  logic [2*NC-1:0] sel1, sel2;
  logic [DW-1:0] din1, din2, dout1, dout2;
  logic [NC*DW-1:0] do_o;
  logic [NC-1:0] act;

  logic b_cs1, b_cs2, b_rw1, b_rw2;
  logic [2*NC2-1:0] b_sel1, b_sel2;
  logic [DW2-1:0] b_din1, b_din2, b_dout1, b_dout2;
  logic [NC2*DW2-1:0] b_do;
  logic [NC2-1:0] b_act;

  int total = 0, bad = 0, cyc = 0;

  // Model: each channel remembers its last trigger edge, value and pulse length.
  logic [DW-1:0] m_val [NC];
  int            m_t   [NC];
  int            m_L   [NC];
  logic [CW-1:0] m_len [NC];
  logic [DW-1:0] m_d1, m_d2;

  always #5 SYSCLK = ~SYSCLK;

  gpo_pulse_bank dut (
    .SYSCLK(SYSCLK), .RESET_N(RESET_N),
    .PORT_CS1(cs1), .PORT_CS2(cs2), .OFFSET_SEL1(sel1), .OFFSET_SEL2(sel2),
    .RD_WR1(rw1), .RD_WR2(rw2), .DIN1(din1), .DIN2(din2),
    .DOUT1(dout1), .DOUT2(dout2), .DO(do_o), .ACTIVE(act)
  );

  gpo_pulse_bank #(.NUM_CH(NC2), .DW(DW2), .CNT_W(8), .GPO_DFT(16'hFFFF), .LEN_DFT(8'd1)) dut2 (
    .SYSCLK(SYSCLK), .RESET_N(RESET_N),
    .PORT_CS1(b_cs1), .PORT_CS2(b_cs2), .OFFSET_SEL1(b_sel1), .OFFSET_SEL2(b_sel2),
    .RD_WR1(b_rw1), .RD_WR2(b_rw2), .DIN1(b_din1), .DIN2(b_din2),
    .DOUT1(b_dout1), .DOUT2(b_dout2), .DO(b_do), .ACTIVE(b_act)
  );

  function automatic logic [DW-1:0] mv(int ch, int k);
    if (m_L[ch] == 0) return m_val[ch];
    return (k < m_t[ch] + m_L[ch]) ? m_val[ch] : DFT;
  endfunction

  function automatic logic ma(int ch, int k);
    return (m_L[ch] != 0) && (k < m_t[ch] + m_L[ch]);
  endfunction

  function automatic logic [NC*DW-1:0] exp_do();
    logic [NC*DW-1:0] r;
    for (int i = 0; i < NC; i++) r[i*DW +: DW] = mv(i, cyc);
    return r;
  endfunction

  function automatic logic [NC-1:0] exp_act();
    logic [NC-1:0] r;
    for (int i = 0; i < NC; i++) r[i] = ma(i, cyc);
    return r;
  endfunction

  function automatic logic [DW-1:0] mrd(logic [2*NC-1:0] s);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < NC; i++) begin
      if (s[i])    r = r | mv(i, cyc);
      if (s[NC+i]) r = r | m_len[i];
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_val[i] = DFT; m_t[i] = 0; m_L[i] = 0; m_len[i] = 8'd1;
    end
    m_d1 = '0; m_d2 = '0;
  endtask

  task automatic idle();
    cs1 = 0; cs2 = 0; rw1 = 0; rw2 = 0; sel1 = '0; sel2 = '0; din1 = '0; din2 = '0;
    b_cs1 = 0; b_cs2 = 0; b_rw1 = 0; b_rw2 = 0; b_sel1 = '0; b_sel2 = '0; b_din1 = '0; b_din2 = '0;
  endtask

  // Advance one clock edge, applying the currently driven bus cycle to the model.
  task automatic tick();
    int e;
    logic [DW-1:0] n1, n2;
    logic [CW-1:0] ol [NC];
    e  = cyc + 1;
    n1 = (cs1 & rw1) ? mrd(sel1) : m_d1;
    n2 = (cs2 & rw2) ? mrd(sel2) : m_d2;
    for (int i = 0; i < NC; i++) ol[i] = m_len[i];
    for (int i = 0; i < NC; i++) begin
      if (cs2 & ~rw2 & sel2[i]) begin m_val[i] = din2; m_t[i] = e; m_L[i] = ol[i]; end
      if (cs1 & ~rw1 & sel1[i]) begin m_val[i] = din1; m_t[i] = e; m_L[i] = ol[i]; end
      if (cs2 & ~rw2 & sel2[NC+i]) m_len[i] = din2;
      if (cs1 & ~rw1 & sel1[NC+i]) m_len[i] = din1;
    end
    m_d1 = n1; m_d2 = n2;
    @(posedge SYSCLK);
    cyc = e;
    #1;
  endtask

  task automatic wr(int port, int off, logic [DW-1:0] d);
    if (port == 1) begin cs1 = 1; rw1 = 0; sel1 = '0; sel1[off] = 1'b1; din1 = d; end
    else           begin cs2 = 1; rw2 = 0; sel2 = '0; sel2[off] = 1'b1; din2 = d; end
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    model_reset();
    RESET_N = 1'b1;
    #1 RESET_N = 1'b0;
    repeat (3) tick();
    total++;
    if (do_o !== '0) begin bad++; $display("FAIL reset_do_held: got %h want 0", do_o); end
    #2 RESET_N = 1'b1;
    repeat (10) tick();
    total++;
    if (do_o !== '0) begin bad++; $display("FAIL reset_do: got %h want 0", do_o); end
    total++;
    if (act !== '0) begin bad++; $display("FAIL reset_active: got %h want 0", act); end
    total++;
    if (dout1 !== 8'h00 || dout2 !== 8'h00) begin
      bad++; $display("FAIL reset_dout: got %h/%h want 00/00", dout1, dout2);
    end
    cs1 = 1; rw1 = 1; sel1 = '0; sel1[NC+3] = 1'b1;
    tick();
    idle();
    total++;
    if (dout1 !== 8'h01) begin bad++; $display("FAIL reset_len3_read: got %h want 01", dout1); end
  endtask

  task automatic test_default_pulse();
    logic [NC*DW-1:0] e;
    e = '0; e[2*DW +: DW] = 8'hA5;
    wr(1, 2, 8'hA5);
    total++;
    if (do_o !== e) begin bad++; $display("FAIL default_pulse_hi: got %h want %h", do_o, e); end
    total++;
    if (act !== 16'h0004) begin bad++; $display("FAIL default_pulse_act: got %h want 0004", act); end
    tick();
    total++;
    if (do_o !== '0) begin bad++; $display("FAIL default_pulse_lo: got %h want 0", do_o); end
    total++;
    if (act !== '0) begin bad++; $display("FAIL default_pulse_act_lo: got %h want 0", act); end
  endtask

  task automatic test_prog_length();
    wr(2, NC+5, 8'd4);
    wr(1, 5, 8'h3C);
    for (int j = 0; j < 4; j++) begin
      total++;
      if (do_o[5*DW +: DW] !== 8'h3C || act[5] !== 1'b1) begin
        bad++; $display("FAIL prog_len_hi[%0d]: got %h/%b want 3c/1", j, do_o[5*DW +: DW], act[5]);
      end
      if (j == 1) begin cs2 = 1; rw2 = 1; sel2 = '0; sel2[5] = 1'b1; end
      tick();
      idle();
      if (j == 1) begin
        total++;
        if (dout2 !== 8'h3C) begin bad++; $display("FAIL prog_len_read_mid: got %h want 3c", dout2); end
      end
    end
    total++;
    if (do_o[5*DW +: DW] !== 8'h00 || act[5] !== 1'b0) begin
      bad++; $display("FAIL prog_len_end: got %h/%b want 00/0", do_o[5*DW +: DW], act[5]);
    end
    cs2 = 1; rw2 = 1; sel2 = '0; sel2[5] = 1'b1;
    tick();
    idle();
    total++;
    if (dout2 !== 8'h00) begin bad++; $display("FAIL prog_len_read_end: got %h want 00", dout2); end
  endtask

  task automatic test_retrigger();
    wr(1, NC+0, 8'd6);
    wr(1, 0, 8'h11);
    for (int j = 0; j < 3; j++) begin
      total++;
      if (do_o[0 +: DW] !== 8'h11) begin bad++; $display("FAIL retrig_first[%0d]: got %h want 11", j, do_o[0 +: DW]); end
      if (j < 2) tick();
    end
    wr(1, 0, 8'h22);
    for (int j = 0; j < 6; j++) begin
      total++;
      if (do_o[0 +: DW] !== 8'h22 || act[0] !== 1'b1) begin
        bad++; $display("FAIL retrig_second[%0d]: got %h/%b want 22/1", j, do_o[0 +: DW], act[0]);
      end
      tick();
    end
    total++;
    if (do_o[0 +: DW] !== 8'h00 || act[0] !== 1'b0) begin
      bad++; $display("FAIL retrig_end: got %h/%b want 00/0", do_o[0 +: DW], act[0]);
    end
    cs1 = 1; rw1 = 0; sel1 = '0; sel1[1] = 1'b1; din1 = 8'h77;
    cs2 = 1; rw2 = 0; sel2 = '0; sel2[1] = 1'b1; din2 = 8'h88;
    tick();
    idle();
    total++;
    if (do_o[DW +: DW] !== 8'h77) begin bad++; $display("FAIL collision_port1_wins: got %h want 77", do_o[DW +: DW]); end
  endtask

  task automatic test_level_expiry();
    wr(2, NC+7, 8'd0);
    wr(1, 7, 8'hF0);
    for (int j = 0; j < 120; j++) begin
      total++;
      if (do_o[7*DW +: DW] !== 8'hF0 || act[7] !== 1'b0) begin
        bad++; $display("FAIL level_hold[%0d]: got %h/%b want f0/0", j, do_o[7*DW +: DW], act[7]);
      end
      tick();
    end
    wr(1, NC+4, 8'd2);
    wr(2, 4, 8'h5A);
    for (int j = 0; j < 2; j++) begin
      total++;
      if (do_o[4*DW +: DW] !== 8'h5A || act[4] !== 1'b1) begin
        bad++; $display("FAIL expiry_first[%0d]: got %h/%b want 5a/1", j, do_o[4*DW +: DW], act[4]);
      end
      if (j == 0) tick();
    end
    wr(1, 4, 8'hC3);
    for (int j = 0; j < 2; j++) begin
      total++;
      if (do_o[4*DW +: DW] !== 8'hC3 || act[4] !== 1'b1) begin
        bad++; $display("FAIL expiry_collide[%0d]: got %h/%b want c3/1", j, do_o[4*DW +: DW], act[4]);
      end
      tick();
    end
    total++;
    if (do_o[4*DW +: DW] !== 8'h00 || act[4] !== 1'b0) begin
      bad++; $display("FAIL expiry_end: got %h/%b want 00/0", do_o[4*DW +: DW], act[4]);
    end
  endtask

  task automatic test_reset_midpulse();
    wr(1, NC+3, 8'd200);
    wr(1, 3, 8'h99);
    repeat (50) tick();
    total++;
    if (do_o[3*DW +: DW] !== 8'h99 || act[3] !== 1'b1) begin
      bad++; $display("FAIL midpulse_running: got %h/%b want 99/1", do_o[3*DW +: DW], act[3]);
    end
    #3 RESET_N = 1'b0;
    #1;
    total++;
    if (do_o !== '0) begin bad++; $display("FAIL midpulse_reset_do: got %h want 0", do_o); end
    total++;
    if (act !== '0 || dout1 !== 8'h00 || dout2 !== 8'h00) begin
      bad++; $display("FAIL midpulse_reset_act_dout: got %h %h %h want 0 00 00", act, dout1, dout2);
    end
    model_reset();
    #2 RESET_N = 1'b1;
    cs1 = 1; rw1 = 1; sel1 = '0; sel1[NC+3] = 1'b1;
    tick();
    idle();
    total++;
    if (dout1 !== 8'h01) begin bad++; $display("FAIL midpulse_len_reset: got %h want 01", dout1); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      cs1 = ($urandom_range(0, 2) == 0); cs2 = ($urandom_range(0, 2) == 0);
      rw1 = 1'($urandom_range(0, 1));    rw2 = 1'($urandom_range(0, 1));
      din1 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      din2 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      sel1 = '0; sel2 = '0;
      case ($urandom_range(0, 3))
        0:       sel1 = $urandom;
        1, 2:    sel1[$urandom_range(0, 2*NC-1)] = 1'b1;
        default: sel1 = '0;
      endcase
      case ($urandom_range(0, 3))
        0:       sel2 = $urandom;
        1, 2:    sel2[$urandom_range(0, 2*NC-1)] = 1'b1;
        default: sel2 = '0;
      endcase
      tick();
      total++;
      if (do_o !== exp_do()) begin bad++; $display("FAIL rand_do@%0d: got %h want %h", cyc, do_o, exp_do()); end
      total++;
      if (act !== exp_act()) begin bad++; $display("FAIL rand_act@%0d: got %h want %h", cyc, act, exp_act()); end
      total++;
      if (dout1 !== m_d1 || dout2 !== m_d2) begin
        bad++; $display("FAIL rand_dout@%0d: got %h/%h want %h/%h", cyc, dout1, dout2, m_d1, m_d2);
      end
    end
    idle();
  endtask

  task automatic test_params();
    total++;
    if (b_do !== {4{16'hFFFF}} || b_act !== 4'h0) begin
      bad++; $display("FAIL wide_idle: got %h/%h want all ffff/0", b_do, b_act);
    end
    b_cs1 = 1; b_rw1 = 0; b_sel1 = 8'b0000_0010; b_din1 = 16'h1234;
    tick();
    idle();
    total++;
    if (b_do !== 64'hFFFF_FFFF_1234_FFFF || b_act !== 4'b0010) begin
      bad++; $display("FAIL wide_default_pulse: got %h/%h want ffffffff1234ffff/2", b_do, b_act);
    end
    tick();
    total++;
    if (b_do !== {4{16'hFFFF}} || b_act !== 4'h0) begin
      bad++; $display("FAIL wide_default_end: got %h/%h want all ffff/0", b_do, b_act);
    end
    b_cs2 = 1; b_rw2 = 0; b_sel2 = 8'b0100_0000; b_din2 = 16'h0005;
    tick();
    idle();
    b_cs2 = 1; b_rw2 = 0; b_sel2 = 8'b0000_0100; b_din2 = 16'hBEEF;
    tick();
    idle();
    for (int j = 0; j < 5; j++) begin
      total++;
      if (b_do !== 64'hFFFF_BEEF_FFFF_FFFF || b_act !== 4'b0100) begin
        bad++; $display("FAIL wide_len5[%0d]: got %h/%h want ffffbeefffffffff/4", j, b_do, b_act);
      end
      tick();
    end
    total++;
    if (b_do !== {4{16'hFFFF}} || b_act !== 4'h0) begin
      bad++; $display("FAIL wide_len5_end: got %h/%h want all ffff/0", b_do, b_act);
    end
    b_cs1 = 1; b_rw1 = 1; b_sel1 = 8'b0100_0000;
    tick();
    idle();
    total++;
    if (b_dout1 !== 16'h0005) begin bad++; $display("FAIL wide_len_read: got %h want 0005", b_dout1); end
  endtask

  initial begin
    test_reset();
    test_default_pulse();
    test_prog_length();
    test_retrigger();
    test_level_expiry();
    test_reset_midpulse();
    test_random();
    test_params();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gpo_pulse_bank.md
# gpo_pulse_bank

Parametrised, register-mapped bank of pulse-generating general-purpose outputs on the dual-port (I2C-side host interface) register bus. Each channel drives a DW-bit output that idles at GPO_DFT. A write to the channel's data offset drives the written value for a programmable number of SYSCLK cycles, then returns it to GPO_DFT. Either host port can trigger and read back any channel. A per-channel length register selects between a timed pulse and level (latched) mode.

## Interface
- NUM_CH, 16, number of output channels (1..16)
- DW, 8, data width of DIN/DOUT/each output channel
- CNT_W, 8, pulse-length register/counter width
- GPO_DFT, 8'h0 (DW bits), idle value of every output channel
- LEN_DFT, 1, reset value of every length register (CNT_W bits)
- SYSCLK  in  1  system clock, all logic on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- PORT_CS1 / PORT_CS2  in  1  port 1/2 block select
- OFFSET_SEL1 / OFFSET_SEL2  in  2*NUM_CH  one-hot offset select; bit i = data reg of channel i, bit NUM_CH+i = length reg of channel i
- RD_WR1 / RD_WR2  in  1  1 = read, 0 = write
- DIN1 / DIN2  in  DW  write data (length writes use DIN[CNT_W-1:0], zero-extended if CNT_W > DW)
- DOUT1 / DOUT2  out  DW  registered read data
- DO  out  NUM_CH*DW  channel outputs, channel i at [i*DW +: DW]
- ACTIVE  out  NUM_CH  bit i = 1 while channel i timed pulse in progress

## Operation
- Write strobe, port p, offset s: wr_p[s] = PORT_CS_p & OFFSET_SEL_p[s] & ~RD_WR_p. Read strobe: rd_p = PORT_CS_p & RD_WR_p.
- Per channel i: data register DO_i, length register LEN_i, down-counter CNT_i.
- Data write to channel i (either port): DO_i <= DIN, CNT_i <= LEN_i.
- Both ports write the same register in the same cycle: port 1 wins. Different registers in the same cycle: both take effect.
- Timed mode (LEN_i ≥ 1): every edge without a new write, if CNT_i > 1 then CNT_i--. If CNT_i == 1 then CNT_i <= 0 and DO_i <= GPO_DFT. If CNT_i == 0, DO_i holds.
- Level mode (LEN_i == 0): written value is held until the next data write. ACTIVE_i stays 0.
- ACTIVE_i = (CNT_i != 0), combinational from the counter register.
- Retrigger while active: the new value and a full LEN_i reload take effect immediately. There is no glitch to GPO_DFT in between.
- Write to the data register coincident with expiry (CNT_i == 1): the write wins, DO_i = new DIN, CNT_i = LEN_i.
- Length write: LEN_i <= DIN[CNT_W-1:0]. Takes effect only at the next trigger; an in-flight pulse keeps its count.
- Reads, port p: on rd_p, DOUT_p <= OR over selected offsets of (current DO_i for data offsets, zero-extended LEN_i for length offsets). DOUT_p holds its value when rd_p = 0. Multiple select bits return the bitwise OR of the selected registers.
- Selects at bit positions ≥ 2*NUM_CH do not exist. An all-zero OFFSET_SEL on a read returns 0.
- Reset: DO_i = GPO_DFT, LEN_i = LEN_DFT, CNT_i = 0, ACTIVE = 0, DOUT1 = DOUT2 = 0. Reset asserted mid-pulse aborts immediately and asynchronously to these values.

## Timing
- Write sampled at edge k: DO_i = DIN from edge k through edge k+LEN_i−1, and returns to GPO_DFT at edge k+LEN_i. The pulse is exactly LEN_i cycles wide. With LEN_DFT = 1 this is a single-cycle pulse.
- ACTIVE_i is high for the same LEN_i cycles as the pulse.
- Maximum pulse: 2^CNT_W − 1 cycles.
- Read latency: 1 cycle, DOUT valid after the edge that samples rd_p.
- A read in the cycle after a write returns the newly written value.
- All outputs are registered or derived from registers. There are no combinational paths from inputs to outputs.

## Test plan
- Reset: NUM_CH=16, GPO_DFT=8'h00. Release reset and idle 10 cycles -> all DO = 0, ACTIVE = 0, DOUT1/2 = 0. Read length offset 3 -> 8'h01.
- Default pulse: port 1 writes 8'hA5 to channel 2 -> DO[2] = A5 for exactly 1 cycle, then 00. ACTIVE[2] high for 1 cycle. All other channels stay 00.
- Programmed length: port 2 writes LEN_5 = 4, then port 1 writes 8'h3C to channel 5 -> DO[5] = 3C for 4 cycles. A read of channel 5 by port 2 during cycle 2 returns 3C; a read after expiry returns 00.
- Retrigger and collision: with LEN_0 = 6, write 8'h11 to channel 0, then write 8'h22 at cycle 3 -> DO[0] = 11 for 3 cycles, then 22 for 6 cycles, with no 00 in between. Simultaneous port 1 8'h77 / port 2 8'h88 writes to channel 1 -> DO[1] = 77.
- Level mode and expiry collision: LEN_7 = 0, write 8'hF0 to channel 7 -> held for 100+ cycles with ACTIVE[7] = 0. Separately, with LEN = 2, a second write landing on the expiry cycle -> new value held for a full 2 cycles.
- Reset mid-pulse and parameters: with LEN = 200 on a running pulse, assert RESET_N low mid-cycle -> DO, ACTIVE and LEN return to reset values immediately. Rerun the pulse test with NUM_CH=4, DW=16, GPO_DFT=16'hFFFF -> idle value is FFFF and pulse widths are correct.
